ram_bus_ctl: RTL
================

RAM_BUS_CTL -- requirements
Module: ram_bus_ctl

Interface
REQ-001 Parameter: ADDR_W, 16, byte-address width.
REQ-002 Parameter: BYTES, 2, byte lanes per word; power of two, 2..8.
REQ-003 Parameter: DEPTH, 32768, implemented words; DEPTH*BYTES <= 2**ADDR_W.
REQ-004 Parameter: WAIT, 0, wait states inserted before completion; 0..15.
REQ-005 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-006 Port: reset  in  1  asynchronous, active-high reset.
REQ-007 Port: req  in  1  request strobe; sampled only in IDLE.
REQ-008 Port: we  in  1  1 = write, 0 = read; captured with req.
REQ-009 Port: byte_op  in  1  1 = single-byte access, 0 = full word; captured with req.
REQ-010 Port: addr  in  ADDR_W  byte address; captured with req.
REQ-011 Port: din  in  8*BYTES  write data; captured with req.
REQ-012 Port: dout  out  8*BYTES  read data; valid in the ack cycle and held until the next accept.
REQ-013 Port: ack  out  1  one-cycle completion pulse.
REQ-014 Port: nxm  out  1  one-cycle nonexistent-memory pulse, in place of ack.
REQ-015 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-016 States: IDLE, WAIT, ACCESS, DONE; encoding comes from the shared package.
REQ-017 IDLE with req=1: capture we/byte_op/addr/din, load the wait counter with WAIT, go to WAIT if WAIT>0, else ACCESS.
REQ-018 WAIT: decrement the counter each cycle; go to ACCESS in the cycle after it reads 1.
REQ-019 ACCESS: address word index = addr[ADDR_W-1:log2(BYTES)], lane = addr[log2(BYTES)-1:0].
REQ-020 ACCESS with word index >= DEPTH: no array write, nxm=1 for this cycle, dout unchanged, next state IDLE.
REQ-021 ACCESS in range, write word: all lanes written from din; addr lane bits ignored (word-aligned).
REQ-022 ACCESS in range, write byte: only the selected lane written, with data din[7:0].
REQ-023 ACCESS in range: array read is synchronous; next state DONE.
REQ-024 DONE: ack=1; dout = full word (word read), or selected lane in dout[7:0] with all upper bits 0 (byte read); next state IDLE.
REQ-025 DONE after a write: dout shows post-write array contents, using the same formatting as a read.
REQ-026 Latency, req accepted to ack: WAIT+2 cycles; to nxm: WAIT+1 cycles.
REQ-027 req held high: a new request is accepted in every IDLE cycle, so back-to-back throughput is one access per WAIT+3 cycles.
REQ-028 req, we, byte_op, addr and din are ignored outside IDLE; captured values are not disturbed.
REQ-029 ack and nxm are never high in the same cycle.

Reset
REQ-030 On reset assertion: state=IDLE, ack=0, nxm=0, busy=0, dout=0, wait counter=0, capture registers=0, immediately and without a clock edge.
REQ-031 Reset in WAIT or ACCESS aborts the access: no array write occurs and no ack/nxm is issued.
REQ-032 Array contents are not cleared by reset.

Structure
REQ-033 The shared package holds the state enum, the wait-counter width (4), and the lane-index width function log2(BYTES).
REQ-034 One sub-module, ram_lane_array: DEPTH x (8*BYTES) single-port array with per-lane write enables and registered read.
REQ-035 ram_bus_ctl holds only the FSM, capture registers, wait counter, range check and dout formatting.

Verification
REQ-036 WAIT=0, BYTES=2: write word addr 0o500 = 0o012706, then read word 0o500 -> ack 2 cycles after each req; read dout = 0o012706.
REQ-037 Byte write 0x5A to addr 0o501, then word read 0o500 -> dout = 0x5AC6; byte read 0o501 -> dout = 0x005A; byte read 0o500 -> dout = 0x00C6.
REQ-038 DEPTH=1024, word read at byte address 0x0800 -> nxm one cycle after req, no ack, array unchanged.
REQ-039 WAIT=3, req held high for 20 cycles -> ack every 6 cycles; busy low exactly one cycle between accesses.
REQ-040 Reset pulsed during WAIT of a word write of 0xFFFF to 0x0010 -> no ack; a subsequent read of 0x0010 returns the prior value.
REQ-041 BYTES=4: byte write 0xAB to addr 0x0007 -> only lane 3 of word 1 changes; word read 0x0004 -> dout = 0xAB000000 when the word was previously 0.

Source files
------------

// File: rtl/ram_bus_ctl_pkg.sv
// ram_bus_ctl_pkg: shared types and helpers for the RAM bus controller.
//   state_t  - controller FSM states
//   WCNT_W   - wait-state counter width
//   lane_w() - lane-index width, log2 of the byte-lane count
package ram_bus_ctl_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_DONE} state_t;

  localparam int WCNT_W = 4;

  function automatic int lane_w(input int bytes);
    int w;
    w = 0;
    while ((1 << w) < bytes) w++;
    return w;
  endfunction

endpackage

// File: rtl/ram_bus_ctl_if.sv
// ram_bus_if: request/response bus between a master and ram_bus_ctl.
//   req/we/byte_op/addr/din : request, sampled by the slave only when idle
//   dout/ack/nxm/busy       : completion data and status from the slave
interface ram_bus_if #(
  parameter int ADDR_W = 16,
  parameter int BYTES  = 2
);
  logic                 req;
  logic                 we;
  logic                 byte_op;
  logic [ADDR_W-1:0]    addr;
  logic [8*BYTES-1:0]   din;
  logic [8*BYTES-1:0]   dout;
  logic                 ack;
  logic                 nxm;
  logic                 busy;

  modport master (output req, we, byte_op, addr, din,
                  input  dout, ack, nxm, busy);
  modport slave  (input  req, we, byte_op, addr, din,
                  output dout, ack, nxm, busy);
endinterface

// File: rtl/ram_bus_ctl_lane_array.sv
// ram_lane_array: DEPTH x (8*BYTES) single-port RAM, one 8-bit array per lane.
//   clk   - clock
//   en    - access strobe (read and optional write in the same cycle)
//   we    - per-lane write enables
//   addr  - word index
//   wdata - write data, one byte per lane
//   rdata - registered read data; a written lane returns the new byte
module ram_lane_array #(
  parameter int DEPTH = 32768,
  parameter int BYTES = 2,
  parameter int AW    = 15
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [BYTES-1:0]      we,
  input  logic [AW-1:0]         addr,
  input  logic [BYTES-1:0][7:0] wdata,
  output logic [BYTES-1:0][7:0] rdata
);

  for (genvar l = 0; l < BYTES; l++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd;

    // Write-first so a write access reports post-write contents.
    always_ff @(posedge clk) begin
      if (en) begin
        if (we[l]) begin
          mem[addr] <= wdata[l];
          rd        <= wdata[l];
        end else begin
          rd <= mem[addr];
        end
      end
    end

    assign rdata[l] = rd;
  end

endmodule

// File: rtl/ram_bus_ctl.sv
// ram_bus_ctl: word/byte RAM controller with programmable wait states and
// nonexistent-memory detection.
//   clk   - clock, all state changes on the rising edge
//   reset - asynchronous active-high reset
//   bus   - ram_bus_if slave: req/we/byte_op/addr/din in; dout/ack/nxm/busy out
module ram_bus_ctl
  import ram_bus_ctl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int BYTES  = 2,
  parameter int DEPTH  = 32768,
  parameter int WAIT   = 0
) (
  input  logic     clk,
  input  logic     reset,
  ram_bus_if.slave bus
);

  localparam int LW   = lane_w(BYTES);
  localparam int DW   = 8 * BYTES;
  localparam int WI_W = ADDR_W - LW;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WI_W:0] DEPTH_L = (WI_W+1)'(DEPTH);

  state_t              state, state_nx;
  logic [WCNT_W-1:0]   wcnt;
  logic                we_q, byte_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DW-1:0]       din_q, dout_q, rdata, fmt, mem_wd;
  logic [WI_W-1:0]     widx;
  logic [LW-1:0]       lane;
  logic                in_range, accept, mem_en, ack, nxm;
  logic [BYTES-1:0]    lane_mask, mem_we;

  assign widx     = addr_q[ADDR_W-1:LW];
  assign lane     = addr_q[LW-1:0];
  assign in_range = {1'b0, widx} < DEPTH_L;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    mem_en   = 1'b0;
    ack      = 1'b0;
    nxm      = 1'b0;
    case (state)
      ST_IDLE:
        if (bus.req) begin
          accept   = 1'b1;
          state_nx = (WAIT > 0) ? ST_WAIT : ST_ACCESS;
        end
      ST_WAIT:
        if (wcnt <= WCNT_W'(1)) state_nx = ST_ACCESS;
      ST_ACCESS:
        if (in_range) begin
          mem_en   = 1'b1;
          state_nx = ST_DONE;
        end else begin
          nxm      = 1'b1;
          state_nx = ST_IDLE;
        end
      ST_DONE: begin
        ack      = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Byte writes replicate din[7:0] on every lane and enable only one.
  assign lane_mask = BYTES'(1) << lane;
  assign mem_we    = (mem_en && we_q) ? (byte_q ? lane_mask : '1) : '0;
  assign mem_wd    = byte_q ? {BYTES{din_q[7:0]}} : din_q;

  // Byte accesses return the selected lane right-justified, upper bits zero.
  assign fmt = byte_q ? DW'(rdata[{lane, 3'b000} +: 8]) : rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      wcnt    <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q   <= bus.we;
        byte_q <= bus.byte_op;
        addr_q <= bus.addr;
        din_q  <= bus.din;
        wcnt   <= WCNT_W'(WAIT);
      end else if (state == ST_WAIT) begin
        wcnt <= wcnt - WCNT_W'(1);
      end
      if (state == ST_DONE) dout_q <= fmt;
    end
  end

  // dout is live from the array in DONE and held from then on.
  assign bus.dout = (state == ST_DONE) ? fmt : dout_q;
  assign bus.ack  = ack;
  assign bus.nxm  = nxm;
  assign bus.busy = (state != ST_IDLE);

  ram_lane_array #(.DEPTH(DEPTH), .BYTES(BYTES), .AW(AW)) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (widx[AW-1:0]),
    .wdata (mem_wd),
    .rdata (rdata)
  );

endmodule
